// File: rtl/camera_config.sv
// ---------------------------------------------------------------------------
// camera_config
//   Walks a constant table of camera register writes and hands each write, one
//   at a time, to a downstream I2C master using a valid/ready handshake. Two
//   table codes are special: 16'hFFF0 pauses for DELAY_CYCLES clocks (used
//   after the soft reset) and 16'hFFFF ends the sequence. No new word is issued
//   until the I2C master has gone busy and come back idle after the previous
//   word.
//
// Ports
//   clk_i         in   1   clock, all state changes on the rising edge
//   reset_i       in   1   asynchronous active-high reset
//   start_i       in   1   one-cycle request to run the sequence (honoured in
//                          IDLE/DONE only)
//   write_data_o  out  16  {register_address, register_data} for the I2C master
//   valid_o       out  1   write_data_o holds a word not yet accepted
//   ready_i       in   1   I2C master idle / able to accept a word
//   busy_o        out  1   sequence in progress
//   done_o        out  1   sequence finished; held until next start or reset
// ---------------------------------------------------------------------------
module camera_config #(
    parameter int ROM_DEPTH    = 32,
    parameter int DELAY_CYCLES = 100_000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic [15:0] write_data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        busy_o,
    output logic        done_o
);

    localparam int IDX_W = $clog2(ROM_DEPTH);
    localparam int CNT_W = $clog2(DELAY_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROM_DEPTH - 1);
    // DELAY is left on the cycle the counter reads zero, so loading N-1 gives
    // exactly N cycles spent in DELAY.
    localparam logic [CNT_W-1:0] DLY_LOAD   = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [15:0]      DELAY_MARK = 16'hFFF0;
    localparam logic [15:0]      END_MARK   = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE,
        DELAY,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [IDX_W-1:0]   r_index;
    logic [CNT_W-1:0]   r_delay_cnt;
    logic [15:0]        r_wdata;
    logic [15:0]        r_rom_data;
    // Set when the last table slot has been sent without an end marker; the
    // sequence then finishes once the I2C master returns idle.
    logic               r_at_end;
    logic               w_last;

    // Register-write table (OV7670-style bring-up). Slots past the listed
    // entries read as the end marker.
    function automatic logic [15:0] rom_entry(input logic [IDX_W-1:0] addr);
        logic [15:0] v;
        case (int'(addr))
            0:       v = 16'h1280;   // COM7: soft reset
            1:       v = 16'hFFF0;   // settle after reset
            2:       v = 16'h1204;   // COM7: RGB output
            3:       v = 16'h1100;   // CLKRC: internal clock
            4:       v = 16'h0C00;   // COM3
            5:       v = 16'h3E00;   // COM14
            6:       v = 16'h8C00;   // RGB444 off
            7:       v = 16'h0400;   // COM1
            8:       v = 16'h40D0;   // COM15: RGB565 full range
            9:       v = 16'h3A04;   // TSLB
            10:      v = 16'h1418;   // COM9: AGC ceiling
            11:      v = 16'h4FB3;   // MTX1
            12:      v = 16'h50B3;   // MTX2
            13:      v = 16'h5100;   // MTX3
            14:      v = 16'h523D;   // MTX4
            15:      v = 16'h53A7;   // MTX5
            16:      v = 16'h54E4;   // MTX6
            17:      v = 16'h589E;   // MTXS
            18:      v = 16'h3DC0;   // COM13: gamma, UV sat
            default: v = 16'hFFFF;   // end of table
        endcase
        return v;
    endfunction

    assign w_last = (r_index == LAST_IDX);

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start_i) w_next_state = FETCH;
            end
            FETCH: begin
                w_next_state = DECODE;
            end
            DECODE: begin
                if (r_rom_data == END_MARK)        w_next_state = DONE;
                else if (r_rom_data == DELAY_MARK) w_next_state = DELAY;
                else                               w_next_state = SEND;
            end
            SEND: begin
                if (ready_i) w_next_state = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!ready_i) w_next_state = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (ready_i) w_next_state = r_at_end ? DONE : FETCH;
            end
            DELAY: begin
                if (r_delay_cnt == '0) w_next_state = w_last ? DONE : FETCH;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Table read: one-cycle registered lookup issued in FETCH, used in DECODE.
    always_ff @(posedge clk_i) begin
        if (r_state == FETCH) begin
            r_rom_data <= rom_entry(r_index);
        end
    end

    // Index, delay counter and output word
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_index     <= '0;
            r_delay_cnt <= '0;
            r_wdata     <= 16'h0000;
            r_at_end    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_index  <= '0;
                        r_at_end <= 1'b0;
                    end
                end
                DECODE: begin
                    if (r_rom_data == DELAY_MARK) begin
                        r_delay_cnt <= DLY_LOAD;
                    end else if (r_rom_data != END_MARK) begin
                        r_wdata <= r_rom_data;
                    end
                end
                SEND: begin
                    // Transfer edge: never wrap the index past the last slot.
                    if (ready_i) begin
                        if (w_last) r_at_end <= 1'b1;
                        else        r_index  <= r_index + 1'b1;
                    end
                end
                DELAY: begin
                    if (r_delay_cnt == '0) begin
                        if (!w_last) r_index <= r_index + 1'b1;
                    end else begin
                        r_delay_cnt <= r_delay_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status outputs decode straight from the state so reset clears them
    // without waiting for a clock.
    assign write_data_o = r_wdata;
    assign valid_o      = (r_state == SEND);
    assign busy_o       = (r_state != IDLE) && (r_state != DONE);
    assign done_o       = (r_state == DONE);

endmodule

// File: tb/tb_camera_config.sv
// ---------------------------------------------------------------------------
// tb_camera_config
//   Directed bench for camera_config. Two instances share clock and reset:
//   dut0 uses the full 32-entry table, dut1 is cut to 8 entries so its table
//   holds no end marker. Each instance talks to a behavioural I2C master whose
//   ready drops one cycle after accepting a word and returns 20 cycles later.
// ---------------------------------------------------------------------------
module tb_camera_config;

    logic        clk;
    logic        reset;

    logic        start0, valid0, ready0, busy0, done0;
    logic [15:0] wd0;
    logic        start1, valid1, ready1, busy1, done1;
    logic [15:0] wd1;

    logic        hold0;          // forces dut0's ready low
    logic [1:0]  m_ready;
    logic [1:0]  m_ph [2];
    int          m_cnt [2];

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    int          gaps [$];
    int          low_run;

    int          n_chk;
    int          n_err;

    // Expected register writes of the full table, in order (markers skipped).
    logic [15:0] exp_words [18] = '{
        16'h1280, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00, 16'h8C00,
        16'h0400, 16'h40D0, 16'h3A04, 16'h1418, 16'h4FB3, 16'h50B3,
        16'h5100, 16'h523D, 16'h53A7, 16'h54E4, 16'h589E, 16'h3DC0
    };

    camera_config #(.ROM_DEPTH(32), .DELAY_CYCLES(10)) dut0 (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start0),
        .write_data_o (wd0),
        .valid_o      (valid0),
        .ready_i      (ready0),
        .busy_o       (busy0),
        .done_o       (done0)
    );

    camera_config #(.ROM_DEPTH(8), .DELAY_CYCLES(10)) dut1 (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start1),
        .write_data_o (wd1),
        .valid_o      (valid1),
        .ready_i      (ready1),
        .busy_o       (busy1),
        .done_o       (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ready0 = m_ready[0] & ~hold0;
    assign ready1 = m_ready[1];

    // Behavioural I2C masters
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ready <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                m_ph[i]  <= 2'd0;
                m_cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (m_ph[i])
                    2'd0: if ((i == 0) ? (valid0 && ready0) : (valid1 && ready1)) m_ph[i] <= 2'd1;
                    2'd1: begin
                        m_ready[i] <= 1'b0;
                        m_cnt[i]   <= 19;
                        m_ph[i]    <= 2'd2;
                    end
                    default: begin
                        if (m_cnt[i] == 0) begin
                            m_ready[i] <= 1'b1;
                            m_ph[i]    <= 2'd0;
                        end else begin
                            m_cnt[i] <= m_cnt[i] - 1;
                        end
                    end
                endcase
            end
        end
    end

    // Transfer capture and valid-low run lengths, sampled mid-cycle.
    initial low_run = 0;
    always @(negedge clk) begin
        if (!valid0) begin
            low_run = low_run + 1;
        end else if (low_run != 0) begin
            gaps.push_back(low_run);
            low_run = 0;
        end
        if (valid0 && ready0) q0.push_back(wd0);
        if (valid1 && ready1) q1.push_back(wd1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid0(input int limit);
        int k;
        k = 0;
        while (!valid0 && k < limit) begin
            tick();
            k++;
        end
        if (!valid0) chk("timeout_valid0", 0, 1);
    endtask

    task automatic wait_q0(input int n, input int limit);
        int k;
        k = 0;
        while (q0.size() < n && k < limit) begin
            tick();
            k++;
        end
        if (q0.size() < n) chk("timeout_q0", q0.size(), n);
    endtask

    task automatic wait_done(input int which, input int limit);
        int k;
        k = 0;
        while (((which == 0) ? !done0 : !done1) && k < limit) begin
            tick();
            k++;
        end
        if ((which == 0) ? !done0 : !done1) chk("timeout_done", 0, 1);
    endtask

    initial begin
        int bad;
        logic [15:0] got;

        n_chk  = 0;
        n_err  = 0;
        start0 = 1'b0;
        start1 = 1'b0;
        hold0  = 1'b0;
        reset  = 1'b1;

        // Reset state
        repeat (3) tick();
        chk("rst_wdata", wd0, 16'h0000);
        chk("rst_valid", valid0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        reset = 1'b0;
        repeat (5) tick();
        chk("idle_no_start_busy", busy0, 1'b0);

        // First word held off by ready low for 50 cycles
        hold0 = 1'b1;
        gaps.delete();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("start_busy", busy0, 1'b1);
        chk("start_done", done0, 1'b0);
        wait_valid0(20);
        chk("first_word", wd0, 16'h1280);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 25) start0 = 1'b1;
            if (i == 26) start0 = 1'b0;
            tick();
            if (!valid0 || wd0 != 16'h1280) bad++;
        end
        chk("hold_stable", bad, 0);
        chk("hold_no_xfer", q0.size(), 0);
        hold0 = 1'b0;
        tick();
        chk("xfer_first_ready", valid0, 1'b0);
        chk("xfer_count1", q0.size(), 1);

        // Delay gap: 2 WAIT_BUSY + 20 WAIT_IDLE + 2 + 10 DELAY + 2
        wait_q0(2, 200);
        chk("word2", (q0.size() >= 2) ? q0[1] : 16'hDEAD, 16'h1204);
        chk("gap_delay", (gaps.size() > 0) ? gaps[gaps.size()-1] : -1, 36);
        wait_q0(3, 200);
        chk("gap_plain", (gaps.size() > 0) ? gaps[gaps.size()-1] : -1, 24);

        // Start while busy must be ignored
        repeat (5) tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;

        // Full run
        wait_done(0, 3000);
        chk("run_count", q0.size(), 18);
        for (int i = 0; i < 18; i++) begin
            got = (i < q0.size()) ? q0[i] : 16'hDEAD;
            chk($sformatf("run_word%0d", i), got, exp_words[i]);
        end
        chk("done_done", done0, 1'b1);
        chk("done_busy", busy0, 1'b0);
        chk("done_valid", valid0, 1'b0);

        // Replay
        q0.delete();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("replay_done_clr", done0, 1'b0);
        wait_done(0, 3000);
        chk("replay_count", q0.size(), 18);
        bad = 0;
        for (int i = 0; i < 18; i++) begin
            if (i >= q0.size() || q0[i] != exp_words[i]) bad++;
        end
        chk("replay_words", bad, 0);

        // Reset in the middle of DELAY
        q0.delete();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_q0(1, 200);
        repeat (28) tick();
        chk("in_delay_busy", busy0, 1'b1);
        chk("in_delay_wdata", wd0, 16'h1280);
        reset = 1'b1;
        #1;
        chk("rst_delay_busy", busy0, 1'b0);
        chk("rst_delay_wdata", wd0, 16'h0000);
        chk("rst_delay_valid", valid0, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Reset in the middle of SEND
        hold0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_valid0(20);
        chk("restart_word", wd0, 16'h1280);
        reset = 1'b1;
        #1;
        chk("rst_send_valid", valid0, 1'b0);
        chk("rst_send_wdata", wd0, 16'h0000);
        tick();
        reset = 1'b0;
        hold0 = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle", busy0, 1'b0);
        q0.delete();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_q0(1, 200);
        chk("post_rst_first", (q0.size() >= 1) ? q0[0] : 16'hDEAD, 16'h1280);

        // Truncated table, no end marker
        q1.delete();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done(1, 2000);
        repeat (60) tick();
        chk("short_count", q1.size(), 7);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (i >= q1.size() || q1[i] != exp_words[i]) bad++;
        end
        chk("short_words", bad, 0);
        chk("short_done", done1, 1'b1);
        chk("short_busy", busy1, 1'b0);
        chk("short_valid", valid1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
